// File: rtl/counter_snapshot_pkg.sv
// Shared types and constants for the counter snapshot sequencer.
// The optional timer is enabled by defining COUNTER_SNAPSHOT_TIMER_EN.
package counter_snapshot_pkg;

    localparam int NCNT    = 4;
    localparam int LATENCY = 6;
    localparam int IDX_W   = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DELTA   = 2'd2,
        PUBLISH = 2'd3
    } state_e;

endpackage

// File: rtl/counter_snapshot_ctrl_if.sv
// Bus bundle between the counter bank/host logic and the snapshot sequencer.
// The period field exists only when COUNTER_SNAPSHOT_TIMER_EN is defined.
interface counter_snapshot_ctrl_if #(
    parameter int size = 8
`ifdef COUNTER_SNAPSHOT_TIMER_EN
    ,
    parameter int per_w = 16
`endif
);
    import counter_snapshot_pkg::*;

    logic [size-1:0]  count0;
    logic [size-1:0]  count1;
    logic [size-1:0]  count2;
    logic [size-1:0]  count3;
    logic             sync_req;
    logic [IDX_W-1:0] rd_sel;
    logic [size-1:0]  rd_data;
    logic             ready;
    logic             busy;
    logic             overrun;
    logic             ovr_clr;
`ifdef COUNTER_SNAPSHOT_TIMER_EN
    logic [per_w-1:0] period;
`endif

    modport slave (
`ifdef COUNTER_SNAPSHOT_TIMER_EN
        input  period,
`endif
        input  count0, count1, count2, count3, sync_req, rd_sel, ovr_clr,
        output rd_data, ready, busy, overrun
    );

    modport master (
`ifdef COUNTER_SNAPSHOT_TIMER_EN
        output period,
`endif
        output count0, count1, count2, count3, sync_req, rd_sel, ovr_clr,
        input  rd_data, ready, busy, overrun
    );

endinterface

// File: rtl/counter_snapshot_ctrl_timer.sv
// Free-running period timer: pulses o_expire every i_period clocks.
// A new period is adopted only on reload; a zero period keeps the timer parked at 0.
module snapshot_timer #(
    parameter int per_w = 16
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [per_w-1:0] i_period,
    output logic             o_expire
);
    logic [per_w-1:0] r_cnt;
    logic [per_w-1:0] r_per;
    logic             w_hit;
    logic             w_reload;

    assign w_hit    = (r_per != '0) && (r_cnt == r_per - per_w'(1));
    // A parked timer reloads every cycle so a freshly written period is picked up at once.
    assign w_reload = (r_per == '0) || w_hit;
    assign o_expire = w_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_per <= '0;
        end else if (w_reload) begin
            r_cnt <= '0;
            r_per <= i_period;
        end else begin
            r_cnt <= r_cnt + per_w'(1);
        end
    end

endmodule

// File: rtl/counter_snapshot_ctrl.sv
// Snapshot sequencer: captures four counters together, computes wrap-safe deltas
// one per cycle and publishes them atomically. Optional timer: COUNTER_SNAPSHOT_TIMER_EN.
module counter_snapshot_ctrl
    import counter_snapshot_pkg::*;
#(
    parameter int size = 8,
    parameter int ncnt = NCNT
`ifdef COUNTER_SNAPSHOT_TIMER_EN
    ,
    parameter int per_w = 16
`endif
)(
    input  logic                  clk,
    input  logic                  rst,
    counter_snapshot_ctrl_if.slave bus
);
    localparam logic [1:0] S_IDLE    = IDLE;
    localparam logic [1:0] S_CAPTURE = CAPTURE;
    localparam logic [1:0] S_DELTA   = DELTA;
    localparam logic [1:0] S_PUBLISH = PUBLISH;

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [IDX_W-1:0] r_idx;
    logic             r_ready;
    logic             r_busy;
    logic             r_overrun;
    logic             w_trig;
    logic [size-1:0]  w_count [ncnt];
    logic [size-1:0]  w_bank  [ncnt];

    assign w_count[0] = bus.count0;
    assign w_count[1] = bus.count1;
    assign w_count[2] = bus.count2;
    assign w_count[3] = bus.count3;

`ifdef COUNTER_SNAPSHOT_TIMER_EN
    logic w_tmr_expire;

    snapshot_timer #(
        .per_w (per_w)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_period (bus.period),
        .o_expire (w_tmr_expire)
    );

    assign w_trig = bus.sync_req | w_tmr_expire;
`else
    assign w_trig = bus.sync_req;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (w_trig) w_state_next = S_CAPTURE;
            S_CAPTURE: w_state_next = S_DELTA;
            S_DELTA:   if (r_idx == IDX_W'(NCNT - 1)) w_state_next = S_PUBLISH;
            S_PUBLISH: w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next != S_IDLE);
            r_ready <= (r_state == S_PUBLISH);
            // A dropped trigger beats a simultaneous clear so no loss goes unreported.
            if (w_trig && (r_state != S_IDLE))
                r_overrun <= 1'b1;
            else if (bus.ovr_clr)
                r_overrun <= 1'b0;
            if (r_state == S_CAPTURE)
                r_idx <= '0;
            else if (r_state == S_DELTA)
                r_idx <= r_idx + IDX_W'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < ncnt; gi++) begin : g_lane
            logic [size-1:0] r_cap;
            logic [size-1:0] r_work;
            logic [size-1:0] r_prev;
            logic [size-1:0] r_bank;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cap  <= '0;
                    r_work <= '0;
                    r_prev <= '0;
                    r_bank <= '0;
                end else begin
                    if (r_state == S_CAPTURE)
                        r_cap <= w_count[gi];
                    // Plain modulo subtraction makes the delta correct across counter wrap.
                    if ((r_state == S_DELTA) && (r_idx == IDX_W'(gi))) begin
                        r_work <= r_cap - r_prev;
                        r_prev <= r_cap;
                    end
                    if (r_state == S_PUBLISH)
                        r_bank <= r_work;
                end
            end

            assign w_bank[gi] = r_bank;
        end
    endgenerate

    assign bus.rd_data = w_bank[bus.rd_sel];
    assign bus.ready   = r_ready;
    assign bus.busy    = r_busy;
    assign bus.overrun = r_overrun;

endmodule

// File: tb/tb_counter_snapshot_ctrl.sv
// Scoreboard bench for counter_snapshot_ctrl; the timer scenario runs only
// when COUNTER_SNAPSHOT_TIMER_EN is defined.
module tb_counter_snapshot_ctrl;
    import counter_snapshot_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    counter_snapshot_ctrl_if bus_if ();

    counter_snapshot_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    typedef struct {
        int               cyc;
        logic [3:0][7:0]  d;
    } exp_t;

    exp_t            exp_q[$];
    logic [3:0][7:0] pub_model;
    int              cyc = 0;
    int              n_tests = 0;
    int              n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(int n);
        while (cyc < n) tick();
    endtask

    // c is the cycle in which the trigger is presented to the DUT.
    task automatic push(int c, logic [7:0] d0, logic [7:0] d1, logic [7:0] d2, logic [7:0] d3);
        exp_t e;
        e.cyc  = c + 1 + LATENCY;
        e.d[0] = d0;
        e.d[1] = d1;
        e.d[2] = d2;
        e.d[3] = d3;
        exp_q.push_back(e);
        $display("[TB] expect snapshot %02h %02h %02h %02h at cycle %0d", d0, d1, d2, d3, e.cyc);
    endtask

    task automatic set_counts(logic [7:0] a, logic [7:0] b, logic [7:0] c, logic [7:0] d);
        bus_if.count0 = a;
        bus_if.count1 = b;
        bus_if.count2 = c;
        bus_if.count3 = d;
    endtask

    task automatic snap(logic [7:0] d0, logic [7:0] d1, logic [7:0] d2, logic [7:0] d3);
        push(cyc, d0, d1, d2, d3);
        bus_if.sync_req = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            if (k == 0) bus_if.sync_req = 1'b0;
            check("busy_seq", 32'(bus_if.busy), 32'(k < 6));
        end
    endtask

    // Monitor: pops on every ready pulse, otherwise checks the read bank is stable.
    initial begin
        exp_t e;
        int   s;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) pub_model = '0;
            if (bus_if.ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL ready_unexpected: got ready=1 expected ready=0 at cycle %0d", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("ready_cycle", 32'(cyc), 32'(e.cyc));
                    for (int i = 0; i < 4; i++) begin
                        bus_if.rd_sel = 2'(i);
                        #1;
                        check("rd_data_pub", 32'(bus_if.rd_data), 32'(e.d[i]));
                    end
                    $display("[TB] snapshot at cycle %0d: %02h %02h %02h %02h", cyc,
                             e.d[0], e.d[1], e.d[2], e.d[3]);
                    pub_model = e.d;
                end
            end else begin
                s = cyc % 4;
                bus_if.rd_sel = 2'(s);
                #1;
                check("rd_data_hold", 32'(bus_if.rd_data), 32'(pub_model[s]));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int c;
        rst            = 1'b1;
        bus_if.sync_req = 1'b0;
        bus_if.ovr_clr = 1'b0;
        bus_if.rd_sel  = '0;
        set_counts(8'd0, 8'd0, 8'd0, 8'd0);
`ifdef COUNTER_SNAPSHOT_TIMER_EN
        bus_if.period = '0;
`endif
        repeat (3) tick();
        check("ready_rst", 32'(bus_if.ready), 32'(0));
        check("busy_rst", 32'(bus_if.busy), 32'(0));
        check("overrun_rst", 32'(bus_if.overrun), 32'(0));
        rst = 1'b0;
        tick();

        // Basic snapshot from reset
        set_counts(8'd10, 8'd20, 8'd30, 8'd40);
        snap(8'd10, 8'd20, 8'd30, 8'd40);

        // Wrap in both directions
        bus_if.count0 = 8'hFE;
        snap(8'hF4, 8'h00, 8'h00, 8'h00);
        bus_if.count0 = 8'h03;
        snap(8'h05, 8'h00, 8'h00, 8'h00);
        bus_if.count0 = 8'hFE;
        snap(8'hFB, 8'h00, 8'h00, 8'h00);

        // Coherency: counter1 moves every cycle; value at capture edge is 51
        push(cyc, 8'h00, 8'd31, 8'h00, 8'h00);
        bus_if.count1 = 8'd50;
        bus_if.sync_req = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            if (k == 0) bus_if.sync_req = 1'b0;
            bus_if.count1 = bus_if.count1 + 8'd1;
        end

        // Overrun: second trigger mid-sequence is dropped
        check("overrun_pre", 32'(bus_if.overrun), 32'(0));
        push(cyc, 8'h00, 8'd6, 8'h00, 8'h00);
        bus_if.sync_req = 1'b1;
        tick();
        bus_if.sync_req = 1'b0;
        repeat (2) tick();
        bus_if.sync_req = 1'b1;
        tick();
        bus_if.sync_req = 1'b0;
        check("overrun_set", 32'(bus_if.overrun), 32'(1));
        repeat (4) tick();
        check("overrun_sticky", 32'(bus_if.overrun), 32'(1));
        check("busy_after", 32'(bus_if.busy), 32'(0));
        bus_if.ovr_clr = 1'b1;
        tick();
        bus_if.ovr_clr = 1'b0;
        check("overrun_clr", 32'(bus_if.overrun), 32'(0));

        // Busy trigger coincident with clear: set wins
        push(cyc, 8'h00, 8'h00, 8'h00, 8'h00);
        bus_if.sync_req = 1'b1;
        tick();
        bus_if.sync_req = 1'b0;
        tick();
        bus_if.sync_req = 1'b1;
        bus_if.ovr_clr = 1'b1;
        tick();
        bus_if.sync_req = 1'b0;
        bus_if.ovr_clr = 1'b0;
        check("overrun_set_wins", 32'(bus_if.overrun), 32'(1));
        repeat (5) tick();

        // Idle trigger coincident with clear: accepted and cleared
        bus_if.count2 = 8'h33;
        push(cyc, 8'h00, 8'h00, 8'h15, 8'h00);
        bus_if.sync_req = 1'b1;
        bus_if.ovr_clr = 1'b1;
        tick();
        bus_if.sync_req = 1'b0;
        bus_if.ovr_clr = 1'b0;
        check("overrun_idle_clr", 32'(bus_if.overrun), 32'(0));
        check("busy_idle_trig", 32'(bus_if.busy), 32'(1));
        repeat (6) tick();

        // Reset mid-sequence: nothing published, bank cleared
        set_counts(8'd1, 8'd2, 8'd3, 8'd4);
        bus_if.sync_req = 1'b1;
        tick();
        bus_if.sync_req = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        check("ready_midrst", 32'(bus_if.ready), 32'(0));
        check("busy_midrst", 32'(bus_if.busy), 32'(0));
        rst = 1'b0;
        repeat (3) tick();
        check("busy_postrst", 32'(bus_if.busy), 32'(0));
        set_counts(8'd7, 8'd7, 8'd7, 8'd7);
        snap(8'd7, 8'd7, 8'd7, 8'd7);

`ifdef COUNTER_SNAPSHOT_TIMER_EN
        // Auto-trigger every 10 clocks, then period 3 overruns, then period 0 stops
        c = cyc;
        set_counts(8'd9, 8'd9, 8'd9, 8'd9);
        bus_if.period = 16'd10;
        push(c + 10, 8'd2, 8'd2, 8'd2, 8'd2);
        push(c + 20, 8'd0, 8'd0, 8'd0, 8'd0);
        push(c + 30, 8'd0, 8'd0, 8'd0, 8'd0);
        push(c + 40, 8'd0, 8'd0, 8'd0, 8'd0);
        wait_until(c + 40);
        check("overrun_tmr_pre", 32'(bus_if.overrun), 32'(0));
        bus_if.period = 16'd3;
        wait_until(c + 41);
        bus_if.period = 16'd0;
        wait_until(c + 80);
        check("overrun_tmr", 32'(bus_if.overrun), 32'(1));
        check("busy_tmr_off", 32'(bus_if.busy), 32'(0));
`else
        c = cyc;
        wait_until(c + 10);
`endif

        repeat (4) tick();
        check("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
